// File: rtl/dcm_phase_ctl_if.sv
// dcm_phase_ctl_if: command/status bus between the control registers
// and the DCM phase sequencer. master = register side, slave = sequencer.
interface dcm_phase_ctl_if #(
  parameter int PHASE_W = 9
);
  logic                      cmd_wr;
  logic [1:0]                cmd_op;
  logic signed [PHASE_W-1:0] cmd_data;
  logic                      busy;
  logic signed [PHASE_W-1:0] cur_phase;
  logic [3:0]                err;

  modport master (
    output cmd_wr, cmd_op, cmd_data,
    input  busy, cur_phase, err
  );

  modport slave (
    input  cmd_wr, cmd_op, cmd_data,
    output busy, cur_phase, err
  );
endinterface

// File: rtl/dcm_phase_ctl.sv
// dcm_phase_ctl: resets the SDRAM-clock DCM, waits for lock and walks its
// phase one step at a time toward a commanded target, tracking the phase.
// Ports: sclk/rst_n; bus (cmd_wr/op/data in, busy/cur_phase/err out);
// dcm_rst/dcm_en/dcm_incdec to the DCM; dcm_done/locked/clkin_stopped back.
module dcm_phase_ctl #(
  parameter int PHASE_W    = 9,
  parameter int PHASE_MAX  = 255,
  parameter int RST_CYCLES = 4,
  parameter int STEP_TO    = 4095,
  parameter int LOCK_TO    = 1048575
) (
  input  logic           sclk,
  input  logic           rst_n,
  dcm_phase_ctl_if.slave bus,
  output logic           dcm_rst,
  output logic           dcm_en,
  output logic           dcm_incdec,
  input  logic           dcm_done,
  input  logic           locked,
  input  logic           clkin_stopped
);

  localparam int CW = $clog2(LOCK_TO + 1);
  localparam int EW = PHASE_W + 1;

  typedef logic signed [EW-1:0]      wide_t;
  typedef logic signed [PHASE_W-1:0] ph_t;

  localparam wide_t P_HI = wide_t'(PHASE_MAX);
  localparam wide_t P_LO = wide_t'(-PHASE_MAX);

  typedef enum logic [2:0] {
    S_RST,
    S_LOCKWAIT,
    S_IDLE,
    S_CALC,
    S_STEP,
    S_WAITDONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  ph_t           cur_phase_q, cur_phase_d;
  ph_t           target_q, target_d;
  logic [3:0]    err_q, err_d;
  logic          busy_q, busy_d;
  logic          dcm_rst_q, dcm_rst_d;
  logic          dcm_en_q, dcm_en_d;
  logic          incdec_q, incdec_d;

  logic [3:0]    err_set;
  logic          err_clr;
  wide_t         sum;

  function automatic ph_t sat(input wide_t v);
    ph_t r;
    if (v > P_HI) r = ph_t'(P_HI);
    else if (v < P_LO) r = ph_t'(P_LO);
    else r = ph_t'(v);
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    cur_phase_d = cur_phase_q;
    target_d    = target_q;
    incdec_d    = incdec_q;
    err_set     = '0;
    err_clr     = 1'b0;
    sum         = wide_t'(cur_phase_q) + wide_t'(bus.cmd_data);

    unique case (state_q)
      S_RST: begin
        if (cnt_q == CW'(RST_CYCLES - 1)) state_d = S_LOCKWAIT;
      end
      S_LOCKWAIT: begin
        if (locked) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(LOCK_TO - 1)) begin
          err_set[0] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      S_IDLE: begin
        if (!locked) err_set[1] = 1'b1;
        if (bus.cmd_wr) begin
          unique case (bus.cmd_op)
            2'b00: begin
              target_d = sat(wide_t'(bus.cmd_data));
              state_d  = S_CALC;
            end
            2'b01: begin
              target_d = sat(sum);
              state_d  = S_CALC;
            end
            2'b10: state_d = S_RST;
            2'b11: err_clr = 1'b1;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        if (!locked) begin
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end else if (target_q == cur_phase_q) begin
          state_d = S_IDLE;
        end else begin
          incdec_d = target_q > cur_phase_q;
          state_d  = S_STEP;
        end
      end
      S_STEP: begin
        if (!locked) begin
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_WAITDONE;
        end
      end
      S_WAITDONE: begin
        // dcm_done may still show the previous PSDONE in the first cycle
        if (!locked) begin
          err_set[1] = 1'b1;
          state_d    = S_IDLE;
        end else if (cnt_q != '0 && dcm_done) begin
          cur_phase_d = incdec_q ? cur_phase_q + ph_t'(1)
                                 : cur_phase_q - ph_t'(1);
          state_d     = S_CALC;
        end else if (cnt_q == CW'(STEP_TO - 1)) begin
          err_set[0] = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_RST;
    endcase

    if (bus.cmd_wr && state_q != S_IDLE) err_set[2] = 1'b1;
    if (clkin_stopped) err_set[3] = 1'b1;

    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_RST) begin
      cur_phase_d = '0;
      target_d    = '0;
    end

    // a clear in the same cycle as a new error keeps the new error
    err_d = (err_clr ? 4'b0 : err_q) | err_set;

    // outputs are registered as a function of the next state
    busy_d    = state_d != S_IDLE;
    dcm_rst_d = state_d == S_RST;
    dcm_en_d  = state_d == S_STEP;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RST;
      cnt_q       <= '0;
      cur_phase_q <= '0;
      target_q    <= '0;
      err_q       <= '0;
      busy_q      <= 1'b1;
      dcm_rst_q   <= 1'b1;
      dcm_en_q    <= 1'b0;
      incdec_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_phase_q <= cur_phase_d;
      target_q    <= target_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      dcm_rst_q   <= dcm_rst_d;
      dcm_en_q    <= dcm_en_d;
      incdec_q    <= incdec_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.cur_phase = cur_phase_q;
  assign bus.err       = err_q;
  assign dcm_rst       = dcm_rst_q;
  assign dcm_en        = dcm_en_q;
  assign dcm_incdec    = incdec_q;

endmodule

// File: tb/tb_dcm_phase_ctl.sv
// tb_dcm_phase_ctl: bench for the DCM phase sequencer with a small DCM
// model (lock delay, PSDONE latency) and a scoreboard of command results.
module tb_dcm_phase_ctl;

  logic sclk = 1'b0;
  logic rst_n = 1'b0;
  logic dcm_rst, dcm_en, dcm_incdec;
  logic dcm_done = 1'b1;
  logic locked = 1'b0;
  logic clkin_stopped = 1'b0;

  dcm_phase_ctl_if #(.PHASE_W(9)) bus ();

  dcm_phase_ctl dut (
    .sclk          (sclk),
    .rst_n         (rst_n),
    .bus           (bus),
    .dcm_rst       (dcm_rst),
    .dcm_en        (dcm_en),
    .dcm_incdec    (dcm_incdec),
    .dcm_done      (dcm_done),
    .locked        (locked),
    .clkin_stopped (clkin_stopped)
  );

  always #5 sclk = ~sclk;

  // DCM model
  int lat = 10;
  int lock_dly = 50;
  bit withhold = 0;
  bit force_unlock = 0;
  int dcnt = 0;
  int lcnt = 0;

  always @(posedge sclk) begin
    if (dcm_en) begin
      dcm_done <= 1'b0;
      dcnt     <= lat;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1 && !withhold) dcm_done <= 1'b1;
    end
  end

  always @(posedge sclk) begin
    if (dcm_rst) begin
      lcnt   <= 0;
      locked <= 1'b0;
    end else if (force_unlock) begin
      locked <= 1'b0;
    end else if (lcnt < lock_dly) begin
      lcnt <= lcnt + 1;
    end else begin
      locked <= 1'b1;
    end
  end

  // pulse counters and protocol monitor
  int en_up = 0, en_dn = 0, viol = 0;
  bit prev_en = 0;

  always @(negedge sclk) begin
    int cp;
    cp = bus.cur_phase;
    if (dcm_en === 1'b1) begin
      if (dcm_incdec) en_up++;
      else en_dn++;
      if (prev_en || dcm_rst) viol++;
    end
    if (cp > 255 || cp < -255) viol++;
    prev_en = (dcm_en === 1'b1);
  end

  typedef struct {
    logic [1:0] op;
    int         data;
    int         lat;
    int         phase;
    logic [3:0] err;
    int         up;
    int         dn;
  } vec_t;

  typedef struct {
    int         phase;
    logic [3:0] err;
    int         up;
    int         dn;
  } exp_t;

  vec_t tv[11];
  exp_t sbq[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int data);
    bus.cmd_op   = op;
    bus.cmd_data = 9'(data);
    bus.cmd_wr   = 1'b1;
    @(negedge sclk);
    bus.cmd_wr   = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (!bus.busy) begin
        ok = 1;
        break;
      end
      @(negedge sclk);
    end
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: busy still high after %0d cycles", nm, budget);
    end
  endtask

  task automatic check_rst_state(input string nm);
    int cp;
    cp = bus.cur_phase;
    check({nm, "_ctl"},
          int'({bus.busy, dcm_rst, dcm_en, dcm_incdec, bus.err}),
          int'(8'b1100_0000));
    check({nm, "_phase"}, cp, 0);
  endtask

  // release reset at a negedge and follow the reset/lock sequence
  task automatic reset_release(input string nm);
    int rc, cyc, cp;
    bit ok;
    rc = 0;
    ok = 0;
    rst_n = 1'b1;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (dcm_rst) rc++;
      if (!bus.busy) begin
        ok = 1;
        break;
      end
      @(negedge sclk);
    end
    check({nm, "_rst_len"}, rc, 4);
    n_vec++;
    if (!ok || cyc < 50 || cyc > 70) begin
      n_bad++;
      $display("FAIL %s_lock_time: got %0d cycles expected 50..70", nm, cyc);
    end
    cp = bus.cur_phase;
    check({nm, "_phase"}, cp, 0);
    check({nm, "_err"}, int'(bus.err), 0);
  endtask

  initial begin
    exp_t e;
    int cp;
    bit seen;

    tv[0]  = '{2'd0,    5, 10,    5, 4'h0,   5,   0};
    tv[1]  = '{2'd1,   -7, 10,   -2, 4'h0,   0,   7};
    tv[2]  = '{2'd0,   -2, 10,   -2, 4'h0,   0,   0};
    tv[3]  = '{2'd0,  200,  3,  200, 4'h0, 202,   0};
    tv[4]  = '{2'd1,  100,  3,  255, 4'h0,  55,   0};
    tv[5]  = '{2'd1,  255,  3,  255, 4'h0,   0,   0};
    tv[6]  = '{2'd1, -256,  3,   -1, 4'h0,   0, 256};
    tv[7]  = '{2'd0, -256,  3, -255, 4'h0,   0, 254};
    tv[8]  = '{2'd1, -100,  3, -255, 4'h0,   0,   0};
    tv[9]  = '{2'd3,    0,  3, -255, 4'h0,   0,   0};
    tv[10] = '{2'd2,    0,  3,    0, 4'h0,   0,   0};

    bus.cmd_wr   = 1'b0;
    bus.cmd_op   = 2'b00;
    bus.cmd_data = '0;

    repeat (3) @(negedge sclk);
    check_rst_state("reset");
    reset_release("rel");

    foreach (tv[i]) begin
      lat   = tv[i].lat;
      en_up = 0;
      en_dn = 0;
      sbq.push_back('{tv[i].phase, tv[i].err, tv[i].up, tv[i].dn});
      issue(tv[i].op, tv[i].data);
      wait_idle($sformatf("v%0d_idle", i), 20000);
      e  = sbq.pop_front();
      cp = bus.cur_phase;
      check($sformatf("v%0d_phase", i), cp, e.phase);
      check($sformatf("v%0d_err", i), int'(bus.err), int'(e.err));
      check($sformatf("v%0d_up", i), en_up, e.up);
      check($sformatf("v%0d_dn", i), en_dn, e.dn);
    end

    // PSDONE never arrives: step timeout
    withhold = 1;
    lat      = 3;
    en_up    = 0;
    issue(2'd0, 3);
    repeat (4000) @(negedge sclk);
    check("to_not_early", int'(bus.busy), 1);
    wait_idle("to_idle", 300);
    cp = bus.cur_phase;
    check("to_phase", cp, 0);
    check("to_err", int'(bus.err), 1);
    check("to_pulses", en_up, 1);
    withhold = 0;
    issue(2'd3, 0);
    check("to_clr", int'(bus.err), 0);

    // lock lost mid-sequence
    lat = 10;
    issue(2'd0, 20);
    repeat (40) @(negedge sclk);
    force_unlock = 1;
    wait_idle("ll_idle", 100);
    cp = bus.cur_phase;
    check("ll_err", int'(bus.err), 2);
    check("ll_abort", int'(cp > 0 && cp < 20), 1);
    force_unlock = 0;
    repeat (2) @(negedge sclk);
    sbq.push_back('{0, 4'b0010, 0, 0});
    issue(2'd2, 0);
    wait_idle("relock_idle", 200);
    e  = sbq.pop_front();
    cp = bus.cur_phase;
    check("relock_phase", cp, e.phase);
    check("relock_err", int'(bus.err), int'(e.err));
    issue(2'd3, 0);
    check("ll_clr", int'(bus.err), 0);

    // command while busy is dropped
    en_up = 0;
    issue(2'd0, 10);
    @(negedge sclk);
    issue(2'd0, -50);
    wait_idle("ovr_idle", 500);
    cp = bus.cur_phase;
    check("ovr_phase", cp, 10);
    check("ovr_err", int'(bus.err), 4);
    check("ovr_pulses", en_up, 10);

    // clear and new error in the same cycle: new error survives
    clkin_stopped = 1'b1;
    issue(2'd3, 0);
    clkin_stopped = 1'b0;
    check("clr_vs_new", int'(bus.err), 8);
    issue(2'd3, 0);
    check("clr_final", int'(bus.err), 0);

    // async reset while waiting for PSDONE
    lat  = 10;
    seen = 0;
    issue(2'd0, 30);
    for (int i = 0; i < 50; i++) begin
      if (dcm_en) begin
        seen = 1;
        break;
      end
      @(negedge sclk);
    end
    check("wd_en_seen", int'(seen), 1);
    repeat (3) @(negedge sclk);
    rst_n = 1'b0;
    #1;
    check_rst_state("wd_rst");
    @(negedge sclk);
    reset_release("wd_rel");

    check("protocol", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
